// File: rtl/run_loop_fsm_pkg.sv
// Shared FSM state encodings for the run/loop sequencing blocks.
package run_loop_fsm_pkg;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

endpackage

// File: rtl/wrap_counter.sv
// Up-counter that returns to zero after reaching a programmable limit.
module wrap_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] count_o,
    output logic             wrap_o
);

    logic [WIDTH-1:0] count_q, count_d;

    assign wrap_o  = (count_q == limit_i);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = wrap_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/run_loop_fsm.sv
// Runs num_loop loops of num_cnt cycles each, with abort, loop ticks and a done pulse.
module run_loop_fsm
    import run_loop_fsm_pkg::*;
#(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned LOOP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_run,
    input  logic              i_abort,
    input  logic [CNT_W-1:0]  i_num_cnt,
    input  logic [LOOP_W-1:0] i_num_loop,
    output logic              o_idle,
    output logic              o_running,
    output logic              o_done,
    output logic              o_loop_tick,
    output logic [CNT_W-1:0]  o_cnt_val,
    output logic [LOOP_W-1:0] o_loop_val
);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  num_cnt_q, num_cnt_d;
    logic [LOOP_W-1:0] num_loop_q, num_loop_d;

    logic cnt_clr, cnt_en, cnt_wrap;
    logic loop_clr, loop_en, loop_wrap;

    always_comb begin
        state_d     = state_q;
        num_cnt_d   = num_cnt_q;
        num_loop_d  = num_loop_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        loop_clr    = 1'b0;
        loop_en     = 1'b0;
        o_loop_tick = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    cnt_clr  = 1'b1;
                    loop_clr = 1'b1;
                    if ((i_num_cnt != '0) && (i_num_loop != '0)) begin
                        num_cnt_d  = i_num_cnt;
                        num_loop_d = i_num_loop;
                        state_d    = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (i_abort) begin
                    state_d  = S_IDLE;
                    cnt_clr  = 1'b1;
                    loop_clr = 1'b1;
                end else if (cnt_wrap) begin
                    // Final loop holds both counters for the DONE cycle.
                    if (loop_wrap) begin
                        state_d = S_DONE;
                    end else begin
                        cnt_en      = 1'b1;
                        loop_en     = 1'b1;
                        o_loop_tick = 1'b1;
                    end
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                cnt_clr  = 1'b1;
                loop_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            num_cnt_q  <= '0;
            num_loop_q <= '0;
        end else begin
            state_q    <= state_d;
            num_cnt_q  <= num_cnt_d;
            num_loop_q <= num_loop_d;
        end
    end

    assign o_idle    = (state_q == S_IDLE);
    assign o_running = (state_q == S_RUN);
    assign o_done    = (state_q == S_DONE);

    wrap_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_cnt (
        .clk_i    (clk),
        .reset_i  (reset),
        .clear_i  (cnt_clr),
        .enable_i (cnt_en),
        .limit_i  (num_cnt_q - 1'b1),
        .count_o  (o_cnt_val),
        .wrap_o   (cnt_wrap)
    );

    wrap_counter #(
        .WIDTH (LOOP_W)
    ) u_loop_cnt (
        .clk_i    (clk),
        .reset_i  (reset),
        .clear_i  (loop_clr),
        .enable_i (loop_en),
        .limit_i  (num_loop_q - 1'b1),
        .count_o  (o_loop_val),
        .wrap_o   (loop_wrap)
    );

endmodule

// File: tb/tb_run_loop_fsm.sv
// Directed bench for run_loop_fsm with hand-computed expectations.
module tb_run_loop_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_run;
    logic       i_abort;
    logic [7:0] i_num_cnt;
    logic [3:0] i_num_loop;
    logic       o_idle, o_running, o_done, o_loop_tick;
    logic [7:0] o_cnt_val;
    logic [3:0] o_loop_val;

    int pass_cnt  = 0;
    int total_cnt = 0;

    run_loop_fsm #(
        .CNT_W  (8),
        .LOOP_W (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_run       (i_run),
        .i_abort     (i_abort),
        .i_num_cnt   (i_num_cnt),
        .i_num_loop  (i_num_loop),
        .o_idle      (o_idle),
        .o_running   (o_running),
        .o_done      (o_done),
        .o_loop_tick (o_loop_tick),
        .o_cnt_val   (o_cnt_val),
        .o_loop_val  (o_loop_val)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and return at the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_run = 1'b1;
        i_abort = 1'b1;
        i_num_cnt = 8'd5;
        i_num_loop = 4'd2;
        step();
        step();
        total_cnt++;
        if ({o_idle, o_running, o_done, o_loop_tick} !== 4'b1000)
            $display("FAIL reset_flags got=%b want=1000",
                     {o_idle, o_running, o_done, o_loop_tick});
        else pass_cnt++;
        total_cnt++;
        if ({o_cnt_val, o_loop_val} !== 12'h000)
            $display("FAIL reset_counters got=%h want=000", {o_cnt_val, o_loop_val});
        else pass_cnt++;
        reset = 1'b0;
        i_run = 1'b0;
        i_abort = 1'b0;
        step();
        total_cnt++;
        if (o_idle !== 1'b1) $display("FAIL idle_after_reset got=%b want=1", o_idle);
        else pass_cnt++;
    endtask

    task automatic test_single_loop();
        int bad = 0;
        i_run = 1'b1;
        i_num_cnt = 8'd8;
        i_num_loop = 4'd1;
        step();
        i_run = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (o_running !== 1'b1 || o_cnt_val !== 8'(k) || o_loop_tick !== 1'b0) begin
                $display("FAIL single_run k=%0d got run=%b cnt=%0d tick=%b want 1/%0d/0",
                         k, o_running, o_cnt_val, o_loop_tick, k);
                bad++;
            end
            step();
        end
        total_cnt++;
        if (bad == 0) pass_cnt++;
        total_cnt++;
        if ({o_done, o_running, o_idle} !== 3'b100)
            $display("FAIL single_done got=%b want=100", {o_done, o_running, o_idle});
        else pass_cnt++;
        step();
        total_cnt++;
        if ({o_done, o_running, o_idle} !== 3'b001)
            $display("FAIL single_back_idle got=%b want=001", {o_done, o_running, o_idle});
        else pass_cnt++;
    endtask

    task automatic test_multi_loop();
        int bad = 0;
        int ticks = 0;
        i_run = 1'b1;
        i_num_cnt = 8'd3;
        i_num_loop = 4'd4;
        step();
        i_run = 1'b0;
        for (int k = 0; k < 12; k++) begin
            logic exp_tick;
            exp_tick = (k % 3 == 2) && (k / 3 < 3);
            if (o_running !== 1'b1 || o_cnt_val !== 8'(k % 3) || o_loop_val !== 4'(k / 3)
                || o_loop_tick !== exp_tick || o_done !== 1'b0) begin
                $display("FAIL multi_run k=%0d got cnt=%0d loop=%0d tick=%b want %0d/%0d/%b",
                         k, o_cnt_val, o_loop_val, o_loop_tick, k % 3, k / 3, exp_tick);
                bad++;
            end
            if (o_loop_tick === 1'b1) ticks++;
            step();
        end
        total_cnt++;
        if (bad == 0) pass_cnt++;
        total_cnt++;
        if (ticks !== 3) $display("FAIL multi_tick_count got=%0d want=3", ticks);
        else pass_cnt++;
        total_cnt++;
        if (o_done !== 1'b1 || o_loop_tick !== 1'b0 || o_cnt_val !== 8'd2 || o_loop_val !== 4'd3)
            $display("FAIL multi_done got done=%b tick=%b cnt=%0d loop=%0d want 1/0/2/3",
                     o_done, o_loop_tick, o_cnt_val, o_loop_val);
        else pass_cnt++;
        step();
        total_cnt++;
        if (o_idle !== 1'b1) $display("FAIL multi_back_idle got=%b want=1", o_idle);
        else pass_cnt++;
    endtask

    task automatic test_zero();
        i_run = 1'b1;
        i_num_cnt = 8'd0;
        i_num_loop = 4'd5;
        step();
        i_run = 1'b0;
        total_cnt++;
        if ({o_done, o_running, o_cnt_val, o_loop_val} !== 14'b10_0000_0000_0000)
            $display("FAIL zero_cnt got done=%b run=%b cnt=%0d loop=%0d want 1/0/0/0",
                     o_done, o_running, o_cnt_val, o_loop_val);
        else pass_cnt++;
        step();
        i_run = 1'b1;
        i_num_cnt = 8'd5;
        i_num_loop = 4'd0;
        step();
        i_run = 1'b0;
        total_cnt++;
        if ({o_done, o_running} !== 2'b10)
            $display("FAIL zero_loop got done/run=%b want=10", {o_done, o_running});
        else pass_cnt++;
        step();
        total_cnt++;
        if (o_idle !== 1'b1) $display("FAIL zero_back_idle got=%b want=1", o_idle);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        // Abort in IDLE has no effect.
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        total_cnt++;
        if (o_idle !== 1'b1) $display("FAIL abort_in_idle got=%b want=1", o_idle);
        else pass_cnt++;
        i_run = 1'b1;
        i_num_cnt = 8'd10;
        i_num_loop = 4'd1;
        step();
        i_run = 1'b0;
        repeat (4) step();
        i_abort = 1'b1;
        total_cnt++;
        if (o_running !== 1'b1 || o_cnt_val !== 8'd4 || o_loop_tick !== 1'b0)
            $display("FAIL abort_cycle5 got run=%b cnt=%0d tick=%b want 1/4/0",
                     o_running, o_cnt_val, o_loop_tick);
        else pass_cnt++;
        step();
        i_abort = 1'b0;
        total_cnt++;
        if ({o_idle, o_running, o_done, o_cnt_val, o_loop_val} !== 15'b100_0000_0000_0000)
            $display("FAIL abort_to_idle got idle=%b run=%b done=%b cnt=%0d loop=%0d",
                     o_idle, o_running, o_done, o_cnt_val, o_loop_val);
        else pass_cnt++;
        step();
        total_cnt++;
        if (o_done !== 1'b0 || o_idle !== 1'b1)
            $display("FAIL abort_no_done got done=%b idle=%b want 0/1", o_done, o_idle);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        i_run = 1'b1;
        i_num_cnt = 8'd2;
        i_num_loop = 4'd1;
        step();
        for (int k = 0; k < 8; k++) begin
            logic [2:0] exp;
            case (k % 4)
                0, 1: exp = 3'b010;
                2: exp = 3'b001;
                default: exp = 3'b100;
            endcase
            if ({o_idle, o_running, o_done} !== exp) begin
                $display("FAIL b2b k=%0d got=%b want=%b", k, {o_idle, o_running, o_done}, exp);
                bad++;
            end
            // Perturb the configuration while running; restore it before the restart.
            if (k % 4 == 0) begin
                i_num_cnt = 8'd9;
                i_num_loop = 4'd3;
            end else if (k % 4 == 2) begin
                i_num_cnt = 8'd2;
                i_num_loop = 4'd1;
            end
            step();
        end
        total_cnt++;
        if (bad == 0) pass_cnt++;
        i_run = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_reset_mid_run();
        int runs = 0;
        bit seen_done = 1'b0;
        i_run = 1'b1;
        i_num_cnt = 8'd255;
        i_num_loop = 4'd15;
        step();
        i_run = 1'b0;
        repeat (300) step();
        total_cnt++;
        if (o_running !== 1'b1 || o_cnt_val !== 8'd45 || o_loop_val !== 4'd1)
            $display("FAIL mid_run_pos got run=%b cnt=%0d loop=%0d want 1/45/1",
                     o_running, o_cnt_val, o_loop_val);
        else pass_cnt++;
        reset = 1'b1;
        i_run = 1'b1;
        step();
        total_cnt++;
        if ({o_idle, o_running, o_done, o_loop_tick, o_cnt_val, o_loop_val} !== 16'h8000)
            $display("FAIL mid_run_reset got idle=%b run=%b done=%b tick=%b cnt=%0d loop=%0d",
                     o_idle, o_running, o_done, o_loop_tick, o_cnt_val, o_loop_val);
        else pass_cnt++;
        reset = 1'b0;
        step();
        i_run = 1'b0;
        for (int c = 0; c < 5000 && !seen_done; c++) begin
            if (o_running === 1'b1) runs++;
            if (o_done === 1'b1) seen_done = 1'b1;
            else step();
        end
        total_cnt++;
        if (!seen_done || runs != 3825)
            $display("FAIL max_run got runs=%0d done=%b want 3825/1", runs, seen_done);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        i_run = 1'b0;
        i_abort = 1'b0;
        i_num_cnt = '0;
        i_num_loop = '0;
        @(negedge clk);
        test_reset();
        test_single_loop();
        test_multi_loop();
        test_zero();
        test_abort();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/run_loop_fsm.md
RUN_LOOP_FSM -- requirements
Module: run_loop_fsm

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8: width of the per-loop cycle count.
REQ-002 The block SHALL have parameter LOOP_W, default 4: width of the loop count.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port i_run, input, 1 bit: start request, sampled only in IDLE.
REQ-006 The block SHALL have port i_abort, input, 1 bit: cancel the operation, honoured in RUN.
REQ-007 The block SHALL have port i_num_cnt, input, CNT_W bits: cycles per loop, latched on start.
REQ-008 The block SHALL have port i_num_loop, input, LOOP_W bits: loop count, latched on start.
REQ-009 The block SHALL have port o_idle, output, 1 bit: high in IDLE.
REQ-010 The block SHALL have port o_running, output, 1 bit: high in RUN.
REQ-011 The block SHALL have port o_done, output, 1 bit: one-cycle pulse in DONE.
REQ-012 The block SHALL have port o_loop_tick, output, 1 bit: one-cycle pulse at each intermediate loop wrap.
REQ-013 The block SHALL have port o_cnt_val, output, CNT_W bits: current cycle counter.
REQ-014 The block SHALL have port o_loop_val, output, LOOP_W bits: current loop index.

Function
REQ-015 The block SHALL be a three-state FSM (IDLE, RUN, DONE); any other encoding SHALL go to IDLE on the next cycle.
REQ-016 o_idle, o_running and o_done SHALL be Moore outputs decoded from the current state only.
REQ-017 In IDLE with i_run=1, i_num_cnt!=0 and i_num_loop!=0, the block SHALL latch both values, clear the cycle and loop counters, and enter RUN on the next edge.
REQ-018 In IDLE with i_run=1 and i_num_cnt=0 or i_num_loop=0, the block SHALL enter DONE directly, without RUN; counters SHALL stay at 0.
REQ-019 In RUN, the cycle counter SHALL increment by 1 per cycle.
REQ-020 In RUN, when the cycle counter equals latched num_cnt-1 and the loop counter is below latched num_loop-1, the cycle counter SHALL wrap to 0, the loop counter SHALL increment, and o_loop_tick SHALL be high in that cycle.
REQ-021 In RUN, when the cycle counter equals num_cnt-1 and the loop counter equals num_loop-1, the block SHALL enter DONE with both counters held; o_loop_tick SHALL stay 0.
REQ-022 Total RUN duration SHALL be num_cnt*num_loop cycles; o_done SHALL follow in the next cycle, then the block SHALL return to IDLE.
REQ-023 i_abort=1 in RUN SHALL take priority over every counting transition: next state IDLE, counters cleared, no o_done, no o_loop_tick in that cycle.
REQ-024 i_abort SHALL be ignored in IDLE and DONE.
REQ-025 i_run SHALL be ignored in RUN and DONE; a held i_run SHALL restart from IDLE one cycle after DONE.
REQ-026 Changes on i_num_cnt or i_num_loop after start SHALL have no effect until the next start.
REQ-027 Counter arithmetic SHALL be CNT_W/LOOP_W modulo with no overflow, because the wrap compare bounds each counter; maximum values (all ones) SHALL be supported.

Reset
REQ-028 With reset=1 at a clock edge, state SHALL become IDLE and all counters and latched values SHALL become 0, regardless of the current state, including mid-RUN.
REQ-029 During and after reset, outputs SHALL be: o_idle=1, o_running=0, o_done=0, o_loop_tick=0, o_cnt_val=0, o_loop_val=0.
REQ-030 Reset SHALL take priority over i_run and i_abort.

Structure
REQ-031 The state encodings S_IDLE=2'b00, S_RUN=2'b01 and S_DONE=2'b10 SHALL live in the shared FSM constants package/header, reused by the team's FSM blocks.
REQ-032 The block SHALL use a two-process style: one registered process and one combinational next-state/output process.
REQ-033 The block SHALL instantiate one sub-module, wrap_counter (parametrised width, inputs clear/enable, limit, output wrap flag), twice: once for cycles, once for loops.

Verification
REQ-034 Reset, then i_run pulse with num_cnt=8, num_loop=1 -> o_running for 8 cycles, o_cnt_val 0..7, o_done one cycle, then o_idle.
REQ-035 num_cnt=3, num_loop=4 -> 12 RUN cycles, o_loop_tick at cycles 3, 6 and 9 (o_loop_val 0->1->2->3), one o_done.
REQ-036 i_abort at RUN cycle 5 of num_cnt=10 -> IDLE next cycle, counters 0, no o_done.
REQ-037 i_run with num_cnt=0 -> o_done on the next cycle with no RUN cycle; likewise for num_loop=0.
REQ-038 i_run held high continuously with num_cnt=2, num_loop=1 -> repeating IDLE, RUN, RUN, DONE, IDLE sequence; inputs changed mid-run are ignored.
REQ-039 reset asserted mid-RUN (num_cnt=255, num_loop=15) -> IDLE and all-zero outputs at the next edge; a fresh start then completes in 3825 RUN cycles.
